sdram_init_monitor: RTL and testbench

//  SDRAM-side responder for the init interface: samples Command/Saddr as the SDRAM chip sees them,

---
 rtl/sdram_init_monitor.sv | 223 ++++++++++++++++++++++
 tb/tb_sdram_init_monitor.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_init_monitor.sv
`timescale 1ns/1ps
// sdram_init_monitor
//   Watches the SDRAM command bus exactly as the chip samples it and checks
//   the power-up initialisation sequence: Cke-high NOP period, PRECHARGE ALL,
//   at least REF_NUM AUTO REFRESH, then LOAD MODE, with tRP/tRFC/tMRD gaps.
//   Reports a sticky pass flag, a sticky error flag with the first violation
//   code, the captured mode register and a saturating refresh count.
//
// Ports
//   Clk       in   system clock, everything sampled on the rising edge
//   Rst       in   asynchronous reset, active-high
//   Cke       in   SDRAM clock enable (low = power-up not started)
//   Command   in   {Cs_n,Ras_n,Cas_n,We_n}
//   Saddr     in   SDRAM address bus, A10 selects precharge-all
//   Init_ok   out  sequence completed legally (sticky)
//   Init_err  out  sequence violation seen (sticky)
//   Err_code  out  first violation code, 0 = none
//   Mode_reg  out  Saddr captured at LOAD MODE
//   Ref_cnt   out  accepted AUTO REFRESH commands, saturates at 15
//
// Error codes: 1 command during power-up wait, 2 precharge without A10,
//   3 tRP gap violated, 4 tRFC gap violated, 5 refresh/mode out of order,
//   6 tMRD gap violated, 7 ACT/READ/WRITE/BST before init completes.
module sdram_init_monitor #(
  parameter int ASIZE     = 12,
  parameter int T_POWERUP = 20000,
  parameter int T_RP      = 2,
  parameter int T_RFC     = 7,
  parameter int T_MRD     = 2,
  parameter int REF_NUM   = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Cke,
  input  logic [3:0]       Command,
  input  logic [ASIZE-1:0] Saddr,
  output logic             Init_ok,
  output logic             Init_err,
  output logic [2:0]       Err_code,
  output logic [ASIZE-1:0] Mode_reg,
  output logic [3:0]       Ref_cnt
);

  localparam int TW = (T_POWERUP < 1) ? 1 : $clog2(T_POWERUP + 1);

  localparam logic [TW-1:0] TPU_C    = TW'(T_POWERUP);
  localparam logic [TW-1:0] TRP_M1   = TW'(T_RP - 1);
  localparam logic [TW-1:0] TRFC_M1  = TW'(T_RFC - 1);
  localparam logic [TW-1:0] TMRD_M1  = TW'(T_MRD - 1);
  localparam logic [3:0]    REFN_C   = 4'(REF_NUM);

  typedef enum logic [3:0] {
    S_IDLE, S_POWERUP, S_WAIT_PRE, S_TRP, S_WAIT_REF,
    S_TRFC, S_WAIT_MRS, S_TMRD, S_DONE, S_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  logic [2:0]       code_q, code_d;
  logic [ASIZE-1:0] mode_q, mode_d;
  logic [3:0]       ref_q, ref_d;
  logic [2:0]       viol;

  logic is_nop, is_pre, is_ref, is_mrs, is_ill, a10;

  assign is_nop = Command[3] | (Command == 4'b0111);
  assign is_pre = (Command == 4'b0010);
  assign is_ref = (Command == 4'b0001);
  assign is_mrs = (Command == 4'b0000);
  assign is_ill = ~(is_nop | is_pre | is_ref | is_mrs);
  assign a10    = Saddr[10];

  function automatic logic [TW-1:0] tmr_inc(input logic [TW-1:0] t);
    return (t == {TW{1'b1}}) ? t : t + 1'b1;
  endfunction

  function automatic logic [3:0] ref_inc(input logic [3:0] r);
    return (r == 4'hF) ? r : r + 1'b1;
  endfunction

  // Once the mandatory refreshes are in, a finished gap lands in WAIT_MRS.
  function automatic state_t after_gap(input logic [3:0] r);
    return (r >= REFN_C) ? S_WAIT_MRS : S_WAIT_REF;
  endfunction

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    ok_d    = ok_q;
    err_d   = err_q;
    code_d  = code_q;
    mode_d  = mode_q;
    ref_d   = ref_q;
    viol    = 3'd0;

    case (state_q)
      S_IDLE: begin
        if (Cke) begin
          state_d = S_POWERUP;
          timer_d = '0;
        end
      end
      S_DONE: begin
        if (is_ref) ref_d = ref_inc(ref_q);
      end
      S_ERROR: begin
      end
      default: begin
        // Cke dropping aborts the sequence quietly, even over a violation.
        if (!Cke) begin
          state_d = S_IDLE;
          timer_d = '0;
          ref_d   = '0;
        end else if (is_ill) begin
          viol = 3'd7;
        end else begin
          // Gap states reuse timer starting at 1 for the cycle after the command.
          if (is_pre && a10 && state_q inside {S_POWERUP, S_WAIT_REF, S_WAIT_MRS}
              && !(state_q == S_POWERUP && timer_q < TPU_C)) begin
            if (T_RP > 1) begin
              state_d = S_TRP;
              timer_d = TW'(1);
            end else begin
              state_d = after_gap(ref_q);
            end
          end else begin
            case (state_q)
              S_POWERUP: begin
                if (is_nop)              timer_d = tmr_inc(timer_q);
                else if (timer_q < TPU_C) viol = 3'd1;
                else if (is_pre)          viol = 3'd2;
                else                      viol = 3'd5;
              end
              S_WAIT_REF, S_WAIT_MRS: begin
                if (is_pre) begin
                  viol = 3'd2;
                end else if (is_ref) begin
                  ref_d = ref_inc(ref_q);
                  if (T_RFC > 1) begin
                    state_d = S_TRFC;
                    timer_d = TW'(1);
                  end else begin
                    state_d = after_gap(ref_inc(ref_q));
                  end
                end else if (is_mrs) begin
                  if (state_q == S_WAIT_REF) begin
                    viol = 3'd5;
                  end else begin
                    mode_d = Saddr;
                    if (T_MRD > 1) begin
                      state_d = S_TMRD;
                      timer_d = TW'(1);
                    end else begin
                      ok_d    = 1'b1;
                      state_d = S_DONE;
                    end
                  end
                end
              end
              S_TRP: begin
                if (!is_nop)                 viol = 3'd3;
                else if (timer_q >= TRP_M1)  state_d = after_gap(ref_q);
                else                         timer_d = tmr_inc(timer_q);
              end
              S_TRFC: begin
                if (!is_nop)                 viol = 3'd4;
                else if (timer_q >= TRFC_M1) state_d = after_gap(ref_q);
                else                         timer_d = tmr_inc(timer_q);
              end
              S_TMRD: begin
                if (!is_nop) begin
                  viol = 3'd6;
                end else if (timer_q >= TMRD_M1) begin
                  ok_d    = 1'b1;
                  state_d = S_DONE;
                end else begin
                  timer_d = tmr_inc(timer_q);
                end
              end
              default: begin
                state_d = S_IDLE;
              end
            endcase
          end
        end
        if (viol != 3'd0) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
          code_d  = viol;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 3'd0;
      mode_q  <= '0;
      ref_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      code_q  <= code_d;
      mode_q  <= mode_d;
      ref_q   <= ref_d;
    end
  end

  assign Init_ok  = ok_q;
  assign Init_err = err_q;
  assign Err_code = code_q;
  assign Mode_reg = mode_q;
  assign Ref_cnt  = ref_q;

endmodule

// File: tb/tb_sdram_init_monitor.sv
`timescale 1ns/1ps
// Randomised bench for sdram_init_monitor. The reference model tracks the
// init sequence as "last command kind + cycles since it" rather than states.
module tb_sdram_init_monitor;

  localparam int TP    = 100;
  localparam int TRP   = 2;
  localparam int TRFC  = 7;
  localparam int TMRD  = 2;
  localparam int REFN  = 2;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_MRS = 4'b0000;
  localparam logic [3:0] C_ACT = 4'b0011;

  logic        clk = 1'b0;
  logic        rst;
  logic        cke;
  logic [3:0]  command;
  logic [11:0] saddr;
  logic        init_ok, init_err;
  logic [2:0]  err_code;
  logic [11:0] mode_reg;
  logic [3:0]  ref_cnt;

  int n_vec = 0;
  int n_bad = 0;

  sdram_init_monitor #(
    .ASIZE(12), .T_POWERUP(TP), .T_RP(TRP), .T_RFC(TRFC), .T_MRD(TMRD), .REF_NUM(REFN)
  ) dut (
    .Clk(clk), .Rst(rst), .Cke(cke), .Command(command), .Saddr(saddr),
    .Init_ok(init_ok), .Init_err(init_err), .Err_code(err_code),
    .Mode_reg(mode_reg), .Ref_cnt(ref_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  // Reference model
  typedef enum {K_NONE, K_PRE, K_REF, K_MRS} kind_t;
  bit          m_started, m_ok, m_err;
  int          m_code, m_high, m_gap, m_refs;
  kind_t       m_last;
  logic [11:0] m_mode;

  task automatic model_reset();
    m_started = 0; m_ok = 0; m_err = 0; m_code = 0;
    m_high = 0; m_gap = 0; m_refs = 0; m_last = K_NONE; m_mode = '0;
  endtask

  task automatic model_fail(input int code);
    m_err = 1; m_code = code;
  endtask

  task automatic model_step(input bit ck, input logic [3:0] cmd, input logic [11:0] ad);
    bit nop, ill;
    int need;
    nop = cmd[3] || (cmd == C_NOP);
    ill = !nop && !(cmd inside {C_MRS, C_REF, C_PRE});
    if (m_err) return;
    if (m_ok) begin
      if (cmd == C_REF && m_refs < 15) m_refs++;
      return;
    end
    if (!m_started) begin
      if (ck) begin m_started = 1; m_high = 0; m_last = K_NONE; m_gap = 0; end
      return;
    end
    if (!ck) begin m_started = 0; m_refs = 0; return; end
    if (ill) begin model_fail(7); return; end
    m_gap++;
    if (nop) begin
      if (m_last == K_NONE) m_high++;
      else if (m_last == K_MRS && m_gap >= TMRD - 1) m_ok = 1;
      return;
    end
    if (m_last == K_NONE) begin
      if (m_high < TP) model_fail(1);
      else if (cmd == C_PRE) begin
        if (ad[10]) begin m_last = K_PRE; m_gap = 0; end
        else model_fail(2);
      end else model_fail(5);
      return;
    end
    need = (m_last == K_PRE) ? TRP : (m_last == K_REF) ? TRFC : TMRD;
    if (m_gap < need) begin
      model_fail((m_last == K_PRE) ? 3 : (m_last == K_REF) ? 4 : 6);
      return;
    end
    if (cmd == C_PRE) begin
      if (ad[10]) begin m_last = K_PRE; m_gap = 0; end
      else model_fail(2);
    end else if (cmd == C_REF) begin
      if (m_refs < 15) m_refs++;
      m_last = K_REF; m_gap = 0;
    end else begin
      if (m_refs < REFN) model_fail(5);
      else begin m_mode = ad; m_last = K_MRS; m_gap = 0; end
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("init_ok",  int'(init_ok),  int'(m_ok));
    check("init_err", int'(init_err), int'(m_err));
    check("err_code", int'(err_code), m_code);
    check("mode_reg", int'(mode_reg), int'(m_mode));
    check("ref_cnt",  int'(ref_cnt),  m_refs);
  endtask

  function automatic logic [11:0] rnd_addr(input bit a10);
    logic [11:0] a;
    a = 12'($urandom);
    a[10] = a10;
    return a;
  endfunction

  function automatic logic [3:0] nop_cmd();
    logic [3:0] c;
    c = {1'b1, 3'($urandom)};
    return ($urandom_range(0, 1) == 1) ? C_NOP : c;
  endfunction

  task automatic cyc(input bit ck, input logic [3:0] cmd, input logic [11:0] ad);
    @(negedge clk);
    cke = ck; command = cmd; saddr = ad;
    model_step(ck, cmd, ad);
    @(posedge clk);
    #1 compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    cke = 0; command = C_NOP; rst = 1;
    model_reset();
    #1 compare_all();
    @(negedge clk);
    rst = 0;
  endtask

  // Reset asserted between clock edges; outputs must clear without an edge.
  task automatic reset_mid();
    @(negedge clk);
    cke = 0; command = C_NOP;
    #2 rst = 1;
    model_reset();
    #1 compare_all();
    @(posedge clk);
    #1 compare_all();
    @(negedge clk);
    rst = 0;
  endtask

  // fault: 0 none, 1 early PRE, 2 PRE A10=0, 3 short tRP, 4 short tRFC,
  // 5 MRS too early, 6 cmd in tMRD, 7 ACT in WAIT_REF, 8 Cke drop in tRFC,
  // 9 reset during tMRD
  task automatic run_seq(input int fault, input int nref, input logic [11:0] mode);
    int pad;
    pad = $urandom_range(1, 4);
    for (int i = 0; i < pad; i++) cyc(0, 4'($urandom), rnd_addr(1'($urandom)));
    cyc(1, nop_cmd(), rnd_addr(0));
    pad = TP + $urandom_range(0, 3);
    for (int i = 0; i < pad; i++) begin
      if (fault == 1 && i == 50) cyc(1, C_PRE, rnd_addr(1));
      else cyc(1, nop_cmd(), rnd_addr(1'($urandom)));
    end
    cyc(1, C_PRE, rnd_addr(fault == 2 ? 1'b0 : 1'b1));
    if (fault != 3) begin
      for (int i = 0; i < TRP - 1 + $urandom_range(0, 2); i++) cyc(1, nop_cmd(), rnd_addr(0));
    end
    for (int r = 0; r < nref; r++) begin
      cyc(1, C_REF, rnd_addr(1'($urandom)));
      if (fault == 8 && r == 0) begin
        for (int i = 0; i < 3; i++) cyc(1, nop_cmd(), rnd_addr(0));
        cyc(0, C_NOP, rnd_addr(0));
        return;
      end
      if (fault == 4 && r == 0) begin
        for (int i = 0; i < 2; i++) cyc(1, nop_cmd(), rnd_addr(0));
      end else begin
        for (int i = 0; i < TRFC - 1 + $urandom_range(0, 2); i++) cyc(1, nop_cmd(), rnd_addr(0));
      end
      if (fault == 7 && r == 0) cyc(1, C_ACT, rnd_addr(0));
    end
    cyc(1, C_MRS, mode);
    if (fault == 9) begin
      reset_mid();
      return;
    end
    if (fault == 6) cyc(1, C_REF, rnd_addr(0));
    pad = 3 + $urandom_range(0, 5);
    for (int i = 0; i < pad; i++) begin
      if (i < TMRD) cyc(1, nop_cmd(), rnd_addr(0));
      else cyc(1'($urandom), 4'($urandom), rnd_addr(1'($urandom)));
    end
  endtask

  initial begin
    int f, nr;
    rst = 1; cke = 0; command = C_NOP; saddr = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    rst = 0;

    run_seq(0, 2, 12'h037);
    check("legal_ok", int'(init_ok), 1);
    check("legal_mode", int'(mode_reg), 12'h037);
    do_reset();

    for (int k = 1; k <= 9; k++) begin
      run_seq(k, (k == 5) ? 1 : 2, 12'($urandom));
      if (k == 8) run_seq(0, 2, 12'($urandom));
      else if (k == 9) run_seq(0, 3, 12'($urandom));
      do_reset();
    end

    run_seq(0, 17, 12'($urandom));
    check("ref_sat", int'(ref_cnt), 15);
    do_reset();

    for (int k = 0; k < 25; k++) begin
      f  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 9);
      nr = $urandom_range(1, 4);
      run_seq(f, nr, 12'($urandom));
      if (f != 8 && f != 9 && $urandom_range(0, 1) == 1) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
